// File: rtl/muldiv_unit_with_lock_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | muldiv_unit_with_lock_if : SIC lock-request bus for the shared muldiv   |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
interface muldiv_unit_with_lock_if #(
  parameter int NUM_PORTS = 8,
  parameter int ID_WIDTH  = 16
);
  logic [NUM_PORTS-1:0]               req_valid;
  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_id;
  logic [NUM_PORTS-1:0][1:0]          req_op;
  logic [NUM_PORTS-1:0][31:0]         req_a;
  logic [NUM_PORTS-1:0][31:0]         req_b;
  logic [NUM_PORTS-1:0]               grant;
  logic [31:0]                        ans_hi;
  logic [31:0]                        ans_lo;

  modport master (
    output req_valid, req_id, req_op, req_a, req_b,
    input  grant, ans_hi, ans_lo
  );

  modport slave (
    input  req_valid, req_id, req_op, req_a, req_b,
    output grant, ans_hi, ans_lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_with_lock.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | muldiv_unit_with_lock : shared MULT/DIV unit locked to the oldest issue |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module muldiv_unit_with_lock #(
  parameter int NUM_PORTS = 8,
  parameter int ID_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  muldiv_unit_with_lock_if.slave        bus
);
  localparam int OWN_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [1:0]           op_q, op_d;
  logic [31:0]          a_q, a_d, b_q, b_d;
  logic [31:0]          rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [31:0]          hi_q, hi_d, lo_q, lo_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;

  // Oldest-ID scan; strict "older" keeps the lower port index on ties.
  logic                win_found;
  logic [OWN_W-1:0]    win_idx;
  logic [ID_WIDTH-1:0] win_id, age_diff;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_id    = '0;
    age_diff  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      age_diff = bus.req_id[i] - win_id;
      if (bus.req_valid[i] && (!win_found || age_diff[ID_WIDTH-1])) begin
        win_found = 1'b1;
        win_idx   = OWN_W'(i);
        win_id    = bus.req_id[i];
      end
    end
  end

  logic [1:0]  win_op;
  logic [31:0] win_a, win_b, win_a_mag, win_b_mag;
  assign win_op    = bus.req_op[win_idx];
  assign win_a     = bus.req_a[win_idx];
  assign win_b     = bus.req_b[win_idx];
  assign win_a_mag = (!win_op[0] && win_a[31]) ? -win_a : win_a;
  assign win_b_mag = (!win_op[0] && win_b[31]) ? -win_b : win_b;

  logic owner_valid;
  assign owner_valid = bus.req_valid[owner_q];

  logic [NUM_PORTS-1:0] owner_onehot;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_onehot
    assign owner_onehot[g] = (owner_q == OWN_W'(g));
  end

  // op bit 0 selects unsigned, bit 1 selects divide.
  logic [63:0] mul_a, mul_b, mul_p;
  assign mul_a = op_q[0] ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
  assign mul_b = op_q[0] ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
  assign mul_p = mul_a * mul_b;

  logic [32:0] div_shift, div_sub;
  logic        div_ge, q_neg, r_neg, div_zero;
  logic [31:0] rem_nxt, quo_nxt, rem_fix, quo_fix;
  assign div_shift = {rem_q, quo_q[31]};
  assign div_sub   = div_shift - {1'b0, dvs_q};
  assign div_ge    = ~div_sub[32];
  assign rem_nxt   = div_ge ? div_sub[31:0] : div_shift[31:0];
  assign quo_nxt   = {quo_q[30:0], div_ge};
  assign q_neg     = !op_q[0] && (a_q[31] ^ b_q[31]);
  assign r_neg     = !op_q[0] && a_q[31];
  assign div_zero  = (b_q == 32'd0);
  assign quo_fix   = div_zero ? 32'hFFFF_FFFF : (q_neg ? -quo_nxt : quo_nxt);
  assign rem_fix   = div_zero ? a_q : (r_neg ? -rem_nxt : rem_nxt);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_CALC;
          owner_d = win_idx;
          op_d    = win_op;
          a_d     = win_a;
          b_d     = win_b;
          rem_d   = '0;
          quo_d   = win_a_mag;
          dvs_d   = win_b_mag;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        if (!owner_valid) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!op_q[1]) begin
          state_d = ST_DONE;
          hi_d    = mul_p[63:32];
          lo_d    = mul_p[31:0];
          grant_d = owner_onehot;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_DONE;
            hi_d    = rem_fix;
            lo_d    = quo_fix;
            grant_d = owner_onehot;
          end
        end
      end
      ST_DONE: begin
        if (!owner_valid) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      grant_q <= grant_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.ans_hi = hi_q;
  assign bus.ans_lo = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit_with_lock.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_muldiv_unit_with_lock : directed and random checks of the lock unit  |
// | Revision : 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_muldiv_unit_with_lock;
  localparam int NP = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_unit_with_lock_if #(.NUM_PORTS(NP), .ID_WIDTH(16)) bus ();
  muldiv_unit_with_lock #(.NUM_PORTS(NP), .ID_WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] t_id [NP];
  logic [1:0]  t_op [NP];
  logic [31:0] t_a  [NP];
  logic [31:0] t_b  [NP];
  int          order[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} straight from the arithmetic definition of each op.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    case (op)
      2'd0: return 64'(longint'($signed(a)) * longint'($signed(b)));
      2'd1: return 64'(a) * 64'(b);
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_one(input string tag, input int p, input logic [15:0] id, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int lat;
    bus.req_id[p] = id; bus.req_op[p] = op; bus.req_a[p] = a; bus.req_b[p] = b;
    bus.req_valid[p] = 1'b1;
    @(negedge clk);
    chk({tag, "_lock"}, 64'(bus.grant), 64'd0);
    bus.req_a[p]  = $urandom;
    bus.req_b[p]  = $urandom;
    bus.req_id[p] = 16'($urandom);
    lat = 0;
    while (bus.grant == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), op[1] ? 64'd32 : 64'd1);
    chk({tag, "_grant"}, 64'(bus.grant), 64'd1 << p);
    chk({tag, "_ans"}, {bus.ans_hi, bus.ans_lo}, exp);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk({tag, "_hold"}, {bus.ans_hi, bus.ans_lo}, exp);
    bus.req_valid[p] = 1'b0;
    @(negedge clk);
    chk({tag, "_rel"}, 64'(bus.grant), 64'd0);
  endtask

  // Serves every requester in mask; the model orders them by signed ID offset.
  task automatic serve(input logic [NP-1:0] mask);
    logic [NP-1:0] pend;
    logic [15:0]   refid;
    int w, best, off, lat, gi;
    pend = mask;
    order.delete();
    for (int i = 0; i < NP; i++) begin
      if (mask[i]) begin
        bus.req_id[i] = t_id[i]; bus.req_op[i] = t_op[i];
        bus.req_a[i]  = t_a[i];  bus.req_b[i]  = t_b[i];
        bus.req_valid[i] = 1'b1;
      end
    end
    while (pend != '0) begin
      w = -1; best = 0; refid = '0;
      for (int i = 0; i < NP; i++) begin
        if (pend[i]) begin
          if (w < 0) refid = t_id[i];
          off = int'(shortint'(t_id[i] - refid));
          if (w < 0 || off < best) begin
            w = i;
            best = off;
          end
        end
      end
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (bus.grant == '0 && lat < 40);
      gi = -1;
      for (int i = 0; i < NP; i++) if (bus.grant[i]) gi = i;
      order.push_back(gi);
      chk("arb_grant", 64'(bus.grant), 64'd1 << w);
      chk("arb_lat", 64'(lat), t_op[w][1] ? 64'd33 : 64'd2);
      chk("arb_ans", {bus.ans_hi, bus.ans_lo}, ref_res(t_op[w], t_a[w], t_b[w]));
      bus.req_valid[w] = 1'b0;
      pend[w] = 1'b0;
      @(negedge clk);
      chk("arb_rel", 64'(bus.grant), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] prev;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [15:0] base;
    logic [NP-1:0] mask;
    int p;

    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_id = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_ans", {bus.ans_hi, bus.ans_lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("mult",  3, 16'd5, 2'd0, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_one("multu", 3, 16'd6, 2'd1, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
    run_one("div_neg", 0, 16'd7, 2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_one("divu",  5, 16'd8, 2'd3, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E});
    run_one("div_z", 1, 16'd9, 2'd2, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF});
    run_one("div_ovf", 2, 16'd10, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_one("divu_z", 7, 16'd11, 2'd3, 32'h8000_0005, 32'd0, {32'h8000_0005, 32'hFFFF_FFFF});

    for (int n = 0; n < 14; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      p = $urandom_range(0, NP - 1);
      run_one("rand", p, 16'($urandom), op, a, b, ref_res(op, a, b));
    end

    for (int i = 0; i < NP; i++) begin
      t_op[i] = 2'd0; t_a[i] = 32'($urandom); t_b[i] = 32'($urandom); t_id[i] = '0;
    end
    t_id[1] = 16'h0003; t_id[4] = 16'hFFFE; t_id[6] = 16'hFFFE;
    serve(8'b0101_0010);
    chk("arb_order", 64'({16'(order[0]), 16'(order[1]), 16'(order[2])}), {16'd0, 16'd4, 16'd6, 16'd1});

    for (int r = 0; r < 5; r++) begin
      base = 16'($urandom);
      mask = NP'($urandom_range(1, (1 << NP) - 1));
      for (int i = 0; i < NP; i++) begin
        t_id[i] = base + 16'($urandom_range(0, 6));
        t_op[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        t_a[i]  = 32'($urandom);
        t_b[i]  = 32'($urandom);
      end
      serve(mask);
    end

    // Abort: port 2 divide drops out mid-calculation, port 5 is waiting.
    prev = {bus.ans_hi, bus.ans_lo};
    bus.req_id[2] = 16'd10; bus.req_op[2] = 2'd2; bus.req_a[2] = 32'd1000; bus.req_b[2] = 32'd3;
    bus.req_id[5] = 16'd20; bus.req_op[5] = 2'd0; bus.req_a[5] = 32'hFFFF_FFFD; bus.req_b[5] = 32'd7;
    bus.req_valid[2] = 1'b1; bus.req_valid[5] = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_calc", 64'(bus.grant), 64'd0);
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    chk("abort_grant", 64'(bus.grant), 64'd0);
    chk("abort_ans", {bus.ans_hi, bus.ans_lo}, prev);
    @(negedge clk);
    chk("abort_next_lock", 64'(bus.grant), 64'd0);
    @(negedge clk);
    chk("abort_next_grant", 64'(bus.grant), 64'd1 << 5);
    chk("abort_next_ans", {bus.ans_hi, bus.ans_lo}, ref_res(2'd0, 32'hFFFF_FFFD, 32'd7));
    bus.req_valid[5] = 1'b0;
    @(negedge clk);
    chk("abort_next_rel", 64'(bus.grant), 64'd0);

    // Reset in the middle of a divide.
    bus.req_id[0] = 16'd40; bus.req_op[0] = 2'd3; bus.req_a[0] = 32'd12345; bus.req_b[0] = 32'd11;
    bus.req_valid[0] = 1'b1;
    repeat (21) @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("midrst_grant", 64'(bus.grant), 64'd0);
    chk("midrst_ans", {bus.ans_hi, bus.ans_lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_one("post_rst", 7, 16'd41, 2'd0, 32'd123456, 32'hFFFF_FF00, ref_res(2'd0, 32'd123456, 32'hFFFF_FF00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
